lif_neuron_array: RTL
=====================

Name: lif_neuron_array

Overview:
- Time-multiplexed array of leaky integrate-and-fire neurons; successor to the single-neuron LIF block.
- Parametrised neuron count, voltage width and input gain. Adds a refractory period, a runtime leak shift, saturating arithmetic and a tick/done step handshake.
- Sits between the sensor/current-encoding front end and the spike router of the gait network; one shared update datapath serves every neuron.

Parameters:
N_NEURONS, 4, number of neurons; state RAM depth
V_WIDTH, 16, membrane voltage width (unsigned)
I_WIDTH, 8, per-neuron input current width (unsigned)
GAIN, 20, constant current-to-drive multiplier
R_WIDTH, 4, refractory counter width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; clears all state
tick  in  1  one-cycle pulse; starts one timestep sweep
i_ext  in  N_NEURONS*I_WIDTH  input currents; neuron k at bits [k*I_WIDTH +: I_WIDTH]
thresh  in  V_WIDTH  firing threshold, shared
leak_shift  in  3  leak time constant as a right-shift amount
refrac_len  in  R_WIDTH  refractory timesteps after a spike
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when a sweep completes
spikes  out  N_NEURONS  spike vector of the last completed sweep
overrun  out  1  sticky; tick arrived while busy
rd_addr  in  clog2(N_NEURONS)  voltage readout index
rd_voltage  out  V_WIDTH  voltage[rd_addr], registered, 1-cycle latency

Behaviour:
- Reset (async): all voltages 0, refractory counters 0, busy 0, done 0, spikes 0, overrun 0, rd_voltage 0, index 0. Reset mid-sweep aborts the sweep; no partial spikes are reported.
- Idle + tick at cycle T:
  - At T, snapshot i_ext, thresh, leak_shift and refrac_len.
  - busy is high in cycles T+1..T+N_NEURONS; neuron k is updated in cycle T+1+k.
  - In cycle T+N_NEURONS+1: done=1 for one cycle, busy=0, and spikes is loaded from the per-sweep accumulator. spikes holds until the next done.
- tick while busy: ignored and sets overrun (cleared only by reset). tick in the same cycle as done is also ignored and sets overrun. A tick is accepted only when busy=0 and done=0.
- Per-neuron update, in signed arithmetic of width V_WIDTH+I_WIDTH+6:
  - drive = i*GAIN
  - v_next = v + ((drive - v) >>> leak_shift); the shift is arithmetic, floor toward minus infinity.
  - Clamp v_next to [0, 2^V_WIDTH-1].
- Refractory neuron (counter > 0): voltage forced to 0, counter decremented, no integration, no spike.
- Otherwise the neuron fires if v_next >= thresh: voltage set to 0, counter loaded with refrac_len, spike bit set.
- Otherwise voltage <= v_next and the spike bit is cleared.
- Edge cases:
  - thresh=0: every non-refractory neuron fires each sweep.
  - refrac_len=0: a neuron may integrate again on the next sweep.
  - leak_shift=0: v_next equals the clamped drive.
- rd_voltage reads committed state. A read during a sweep returns the pre- or post-update value depending on whether neuron rd_addr has been processed yet.

Decomposition:
- Package lif_pkg holds: the accumulator width function, the clamp helper, the GAIN default and the sweep state encoding (IDLE, SWEEP, DONE).
- Sub-module lif_update: a purely combinational single-neuron datapath taking (v, refrac, i, thresh, leak_shift, refrac_len) and producing (v_new, refrac_new, spike).
- The array holds state registers, the index counter and control.

Test Plan:
- Integration to threshold. N=4, thresh=100, leak_shift=3, refrac_len=0, i0=10, others 0, repeated ticks.
  -> v0 = 25, 46, 65, 81, 95, then fires on tick 6 (v_next=108): spikes=0001, v0=0. Other neurons stay at 0.
- Refractory. As above with refrac_len=2.
  -> After the spike on tick 6, v0 stays 0 with no spike on ticks 7 and 8; tick 9 gives v0=25.
- Leak decay. i0=10 for 4 ticks (v0=81), then i0=0, one tick.
  -> v0=70 (81 + (-81>>>3) = 81-11).
- Saturation. V_WIDTH=12, i0=255, leak_shift=0, thresh=4095.
  -> v_next clamps to 4095 and the neuron fires on tick 1.
- Handshake and overrun. Tick at T, second tick at T+2.
  -> busy high T+1..T+4, done only at T+5, second tick ignored, overrun=1 until reset.
- Reset mid-sweep. Assert reset at T+2 of a sweep where neuron 0 would fire.
  -> Immediately busy=0, spikes=0, all voltages 0; no done pulse.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron array: sweep state encoding, gain default,
// datapath width and the unsigned clamp used on the membrane voltage.
package lif_pkg;

  localparam int LIF_GAIN_DEFAULT = 20;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Headroom for i*GAIN plus a sign bit, so drive - v never wraps.
  function automatic int acc_width(input int v_width, input int i_width);
    return v_width + i_width + 6;
  endfunction

  function automatic longint clamp_unsigned(input longint x, input int width);
    longint hi;
    hi = (64'sd1 <<< width) - 64'sd1;
    if (x < 64'sd0) begin
      return 64'sd0;
    end else if (x > hi) begin
      return hi;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Control, stimulus and readout bundle of the LIF neuron array.
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 16,
  parameter int I_WIDTH   = 8,
  parameter int R_WIDTH   = 4
);
  localparam int A_WIDTH = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                         tick;
  logic [N_NEURONS*I_WIDTH-1:0] i_ext;
  logic [V_WIDTH-1:0]           thresh;
  logic [2:0]                   leak_shift;
  logic [R_WIDTH-1:0]           refrac_len;
  logic                         busy;
  logic                         done;
  logic [N_NEURONS-1:0]         spikes;
  logic                         overrun;
  logic [A_WIDTH-1:0]           rd_addr;
  logic [V_WIDTH-1:0]           rd_voltage;

  modport master (
    output tick, i_ext, thresh, leak_shift, refrac_len, rd_addr,
    input  busy, done, spikes, overrun, rd_voltage
  );

  modport slave (
    input  tick, i_ext, thresh, leak_shift, refrac_len, rd_addr,
    output busy, done, spikes, overrun, rd_voltage
  );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron LIF step: leaky integration toward i*GAIN,
// clamp, threshold test and refractory countdown.
module lif_update
  import lif_pkg::*;
#(
  parameter int V_WIDTH = 16,
  parameter int I_WIDTH = 8,
  parameter int R_WIDTH = 4,
  parameter int GAIN    = LIF_GAIN_DEFAULT
) (
  input  logic [V_WIDTH-1:0] v,
  input  logic [R_WIDTH-1:0] refrac,
  input  logic [I_WIDTH-1:0] i_cur,
  input  logic [V_WIDTH-1:0] thresh,
  input  logic [2:0]         leak_shift,
  input  logic [R_WIDTH-1:0] refrac_len,
  output logic [V_WIDTH-1:0] v_new,
  output logic [R_WIDTH-1:0] refrac_new,
  output logic               spike
);
  localparam int W = acc_width(V_WIDTH, I_WIDTH);
  localparam logic signed [W-1:0] GAIN_W = W'(GAIN);

  logic signed [W-1:0]  drive_s;
  logic signed [W-1:0]  v_ext_s;
  logic signed [W-1:0]  step_s;
  logic signed [W-1:0]  v_next_s;
  logic [V_WIDTH-1:0]   v_clamp_s;

  // Integrate, clamp, then decide refractory / fire / hold.
  always_comb begin
    drive_s   = $signed(W'(i_cur)) * GAIN_W;
    v_ext_s   = $signed(W'(v));
    step_s    = (drive_s - v_ext_s) >>> leak_shift;
    v_next_s  = v_ext_s + step_s;
    v_clamp_s = V_WIDTH'(clamp_unsigned(longint'(v_next_s), V_WIDTH));
    if (refrac != '0) begin
      v_new      = '0;
      refrac_new = refrac - R_WIDTH'(1);
      spike      = 1'b0;
    end else if (v_clamp_s >= thresh) begin
      v_new      = '0;
      refrac_new = refrac_len;
      spike      = 1'b1;
    end else begin
      v_new      = v_clamp_s;
      refrac_new = '0;
      spike      = 1'b0;
    end
  end
endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one shared lif_update datapath walks every
// neuron once per accepted tick, then reports the sweep's spike vector with done.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 16,
  parameter int I_WIDTH   = 8,
  parameter int GAIN      = LIF_GAIN_DEFAULT,
  parameter int R_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  lif_neuron_array_if.slave bus
);
  localparam int A_WIDTH = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(N_NEURONS - 1);

  logic [V_WIDTH-1:0]           v_q    [N_NEURONS];
  logic [V_WIDTH-1:0]           v_d    [N_NEURONS];
  logic [R_WIDTH-1:0]           ref_q  [N_NEURONS];
  logic [R_WIDTH-1:0]           ref_d  [N_NEURONS];
  logic [1:0]                   state_q, state_d;
  logic [A_WIDTH-1:0]           idx_q, idx_d;
  logic [N_NEURONS-1:0]         acc_q, acc_d;
  logic [N_NEURONS-1:0]         spikes_q, spikes_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         overrun_q, overrun_d;
  logic [V_WIDTH-1:0]           rd_q, rd_d;
  logic [N_NEURONS*I_WIDTH-1:0] iext_q, iext_d;
  logic [V_WIDTH-1:0]           thresh_q, thresh_d;
  logic [2:0]                   shift_q, shift_d;
  logic [R_WIDTH-1:0]           rlen_q, rlen_d;

  logic [I_WIDTH-1:0] i_sel_s;
  logic [V_WIDTH-1:0] v_new_s;
  logic [R_WIDTH-1:0] ref_new_s;
  logic               spike_s;

  assign i_sel_s = iext_q[int'(idx_q) * I_WIDTH +: I_WIDTH];

  lif_update #(
    .V_WIDTH (V_WIDTH),
    .I_WIDTH (I_WIDTH),
    .R_WIDTH (R_WIDTH),
    .GAIN    (GAIN)
  ) u_update (
    .v          (v_q[idx_q]),
    .refrac     (ref_q[idx_q]),
    .i_cur      (i_sel_s),
    .thresh     (thresh_q),
    .leak_shift (shift_q),
    .refrac_len (rlen_q),
    .v_new      (v_new_s),
    .refrac_new (ref_new_s),
    .spike      (spike_s)
  );

  // Sweep control, operand snapshot and per-neuron write-back.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    overrun_d = overrun_q;
    iext_d    = iext_q;
    thresh_d  = thresh_q;
    shift_d   = shift_q;
    rlen_d    = rlen_q;
    v_d       = v_q;
    ref_d     = ref_q;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d  = SWEEP;
          idx_d    = '0;
          acc_d    = '0;
          iext_d   = bus.i_ext;
          thresh_d = bus.thresh;
          shift_d  = bus.leak_shift;
          rlen_d   = bus.refrac_len;
        end else begin
          state_d  = IDLE;
        end
      end
      SWEEP: begin
        v_d[idx_q]   = v_new_s;
        ref_d[idx_q] = ref_new_s;
        acc_d[idx_q] = spike_s;
        overrun_d    = overrun_q | bus.tick;
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          idx_d    = '0;
          spikes_d = acc_d;
        end else begin
          idx_d    = idx_q + A_WIDTH'(1);
        end
      end
      DONE: begin
        overrun_d = overrun_q | bus.tick;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SWEEP);
    done_d = (state_d == DONE);
    rd_d   = v_q[bus.rd_addr];
  end

  // State registers; reset aborts any sweep in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]   <= '0;
        ref_q[k] <= '0;
      end
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      spikes_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_q      <= '0;
      iext_q    <= '0;
      thresh_q  <= '0;
      shift_q   <= 3'd0;
      rlen_q    <= '0;
    end else begin
      v_q       <= v_d;
      ref_q     <= ref_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      rd_q      <= rd_d;
      iext_q    <= iext_d;
      thresh_q  <= thresh_d;
      shift_q   <= shift_d;
      rlen_q    <= rlen_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.spikes     = spikes_q;
  assign bus.overrun    = overrun_q;
  assign bus.rd_voltage = rd_q;
endmodule
